// File: rtl/e3_display_scan_if.sv
// Bus between the E3 converter side and the display scanner: digit word and
// sign in, registered segment/anode drive and status out.
interface e3_display_scan_if;
    logic [15:0] E3_in;
    logic        Sign_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        err;
    logic        frame_done;

    modport master (
        output E3_in, Sign_in, blank_lz,
        input  seg, an, err, frame_done
    );

    modport slave (
        input  E3_in, Sign_in, blank_lz,
        output seg, an, err, frame_done
    );
endinterface

// File: rtl/e3_display_scan.sv
// Five-position multiplexed 7-segment driver for a four-digit excess-3 (or BCD)
// word plus sign, refreshed from a once-per-frame snapshot.
//
// state          | meaning
// ---------------+--------------------------------------------
// POS_UNITS      | units digit lit, an bit0
// POS_TENS       | tens digit lit, an bit1
// POS_HUNDREDS   | hundreds digit lit, an bit2
// POS_THOUSANDS  | thousands digit lit, an bit3
// POS_SIGN       | sign position lit, an bit4; snapshot taken on its last cycle
module e3_display_scan #(
    parameter int DIV        = 50000,
    parameter bit E3_CODED   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    e3_display_scan_if.slave bus
);

    localparam int              CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(DIV - 1);
    localparam logic [15:0]     SHADOW_RST = E3_CODED ? 16'h3333 : 16'h0000;

    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [2:0] {
        POS_UNITS     = 3'd0,
        POS_TENS      = 3'd1,
        POS_HUNDREDS  = 3'd2,
        POS_THOUSANDS = 3'd3,
        POS_SIGN      = 3'd4
    } pos_t;

    pos_t          pos_q;
    pos_t          pos_next;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          capture;

    logic [15:0]   shadow_word_q;
    logic          shadow_sign_q;
    logic [6:0]    seg_q;
    logic [4:0]    an_q;
    logic          err_q;
    logic          frame_done_q;

    logic [6:0]    seg_next;
    logic [4:0]    an_next;

    logic [3:0]    vld;
    logic [3:0]    zero;
    logic [3:0]    blank;
    logic [6:0]    digit_seg [4];
    logic          in_err;

    function automatic logic nib_valid(input logic [3:0] n);
        if (E3_CODED)
            return (n >= 4'd3) && (n <= 4'd12);
        else
            return (n <= 4'd9);
    endfunction

    function automatic logic [3:0] nib_digit(input logic [3:0] n);
        return E3_CODED ? (n - 4'd3) : n;
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    assign tick    = (cnt_q == CNT_LAST);
    assign capture = tick && (pos_q == POS_SIGN);

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    // Blanking chain runs from thousands down; an invalid nibble is never zero,
    // so it stops the chain for every lower digit.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i]  = nib_valid(shadow_word_q[4*i +: 4]);
            zero[i] = vld[i] && (nib_digit(shadow_word_q[4*i +: 4]) == 4'd0);
            in_err  = in_err | ~nib_valid(bus.E3_in[4*i +: 4]);
        end
        blank[3] = bus.blank_lz & zero[3];
        blank[2] = blank[3] & zero[2];
        blank[1] = blank[2] & zero[1];
        blank[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!vld[i])
                digit_seg[i] = SEG_E;
            else if (blank[i])
                digit_seg[i] = SEG_BLANK;
            else
                digit_seg[i] = digit_pattern(nib_digit(shadow_word_q[4*i +: 4]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pos_q <= POS_UNITS;
        else
            pos_q <= pos_next;
    end

    always_comb begin
        pos_next = pos_q;
        an_next  = 5'b00000;
        seg_next = SEG_BLANK;
        case (pos_q)
            POS_UNITS: begin
                an_next  = 5'b00001;
                seg_next = digit_seg[0];
                if (tick) pos_next = POS_TENS;
            end
            POS_TENS: begin
                an_next  = 5'b00010;
                seg_next = digit_seg[1];
                if (tick) pos_next = POS_HUNDREDS;
            end
            POS_HUNDREDS: begin
                an_next  = 5'b00100;
                seg_next = digit_seg[2];
                if (tick) pos_next = POS_THOUSANDS;
            end
            POS_THOUSANDS: begin
                an_next  = 5'b01000;
                seg_next = digit_seg[3];
                if (tick) pos_next = POS_SIGN;
            end
            POS_SIGN: begin
                an_next  = 5'b10000;
                seg_next = shadow_sign_q ? SEG_MINUS : SEG_BLANK;
                if (tick) pos_next = POS_UNITS;
            end
            default: begin
                if (tick) pos_next = POS_UNITS;
            end
        endcase
    end

    // err is loaded together with the shadow word so it always describes what is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_word_q <= SHADOW_RST;
            shadow_sign_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= 5'b00000;
            err_q         <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            seg_q        <= seg_next;
            an_q         <= an_next;
            frame_done_q <= capture;
            if (capture) begin
                shadow_word_q <= bus.E3_in;
                shadow_sign_q <= bus.Sign_in;
                err_q         <= in_err;
            end
        end
    end

    assign bus.seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign bus.an         = ACTIVE_LOW ? ~an_q  : an_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_e3_display_scan.sv
// Scoreboard bench for e3_display_scan with DIV=4, excess-3 input, active-high outputs.
module tb_e3_display_scan;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [4:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t sb[$];

    e3_display_scan_if bus ();

    e3_display_scan #(
        .DIV       (4),
        .E3_CODED  (1'b1),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic bit ok_nib(input logic [3:0] n);
        return (n >= 4'd3) && (n <= 4'd12);
    endfunction

    // Walks digits from the most significant down, carrying "still leading" state.
    function automatic exp_t model_pos(input logic [15:0] w, input logic s,
                                       input logic blz, input int pos);
        exp_t e;
        bit   lead;
        logic [3:0] nib;
        e.err = !(ok_nib(w[3:0]) && ok_nib(w[7:4]) && ok_nib(w[11:8]) && ok_nib(w[15:12]));
        e.an  = 5'(1 << pos);
        e.seg = 7'h00;
        if (pos == 4) begin
            e.seg = s ? 7'h40 : 7'h00;
        end else begin
            lead = blz;
            for (int p = 3; p >= pos; p--) begin
                nib = w[4*p +: 4];
                if (p == pos) begin
                    if (!ok_nib(nib))
                        e.seg = 7'h79;
                    else if (lead && nib == 4'd3 && p != 0)
                        e.seg = 7'h00;
                    else
                        e.seg = pat(int'(nib) - 3);
                end
                lead = lead && ok_nib(nib) && (nib == 4'd3);
            end
        end
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] w, input logic s, input logic blz);
        for (int p = 0; p < 5; p++) sb.push_back(model_pos(w, s, blz, p));
    endtask

    task automatic drive(input logic [15:0] w, input logic s, input logic blz);
        bus.E3_in    = w;
        bus.Sign_in  = s;
        bus.blank_lz = blz;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 100);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_timeout: frame_done=%b after %0d cycles, want 1", bus.frame_done, n);
        end
    endtask

    // Called right after frame_done is seen; samples each position once and
    // optionally changes the inputs while the hundreds digit is lit.
    task automatic check_frame(input bit chg, input logic [15:0] nw, input logic ns);
        exp_t e;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if ((k - 1) % 4 == 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: no expectation for position %0d", (k - 1) / 4);
                end else begin
                    e = sb.pop_front();
                    if (bus.an !== e.an || bus.seg !== e.seg || bus.err !== e.err) begin
                        errors++;
                        $display("FAIL frame_pos%0d: got an=%b seg=%h err=%b, want an=%b seg=%h err=%b",
                                 (k - 1) / 4, bus.an, bus.seg, bus.err, e.an, e.seg, e.err);
                    end
                end
            end
            if (chg && k == 9) begin
                bus.E3_in   = nw;
                bus.Sign_in = ns;
            end
        end
    endtask

    // Entered on a negedge with rst=1; shadow holds 3333, so every digit reads 0.
    task automatic check_release();
        int         first_fd;
        logic [4:0] ea;
        logic [6:0] es;
        first_fd = 0;
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.an !== 5'b00001 || bus.seg !== 7'h3F || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL release_first: got an=%b seg=%h err=%b, want an=00001 seg=3f err=0",
                             bus.an, bus.seg, bus.err);
                end
            end
            if ((k - 1) % 4 == 0) begin
                ea = 5'(1 << ((k - 1) / 4));
                es = ((k - 1) / 4 == 4) ? 7'h00 : 7'h3F;
                checks++;
                if (bus.an !== ea || bus.seg !== es) begin
                    errors++;
                    $display("FAIL release_rotate_k%0d: got an=%b seg=%h, want an=%b seg=%h",
                             k, bus.an, bus.seg, ea, es);
                end
            end
            if (bus.frame_done && first_fd == 0) first_fd = k;
        end
        checks++;
        if (first_fd != 20) begin
            errors++;
            $display("FAIL first_frame_done: got cycle %0d, want 20", first_fd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h3333, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.seg !== 7'h00 || bus.an !== 5'b00000 || bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got seg=%h an=%b err=%b fd=%b, want all zero",
                     bus.seg, bus.an, bus.err, bus.frame_done);
        end
        check_release();
    endtask

    task automatic test_digits();
        int n;
        drive(16'h4B63, 1'b1, 1'b0);
        push_frame(16'h4B63, 1'b1, 1'b0);
        wait_frame(n);
        check_frame(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_blanking();
        int n;
        drive(16'h3338, 1'b0, 1'b1);
        push_frame(16'h3338, 1'b0, 1'b1);
        wait_frame(n);
        check_frame(1'b0, 16'h0, 1'b0);
        drive(16'h3338, 1'b0, 1'b0);
        push_frame(16'h3338, 1'b0, 1'b0);
        wait_frame(n);
        check_frame(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_mid_frame();
        int n;
        drive(16'h5678, 1'b0, 1'b0);
        push_frame(16'h5678, 1'b0, 1'b0);
        wait_frame(n);
        push_frame(16'h3C3C, 1'b1, 1'b0);
        check_frame(1'b1, 16'h3C3C, 1'b1);
        wait_frame(n);
        checks++;
        if (n + 17 != 20) begin
            errors++;
            $display("FAIL frame_spacing: got %0d cycles, want 20", n + 17);
        end
        check_frame(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_invalid();
        int n;
        drive(16'h3033, 1'b0, 1'b1);
        push_frame(16'h3033, 1'b0, 1'b1);
        wait_frame(n);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_at_capture: got err=%b, want 1", bus.err);
        end
        check_frame(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        wait_frame(n);
        repeat (13) @(negedge clk);
        checks++;
        if (bus.an !== 5'b01000 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got an=%b err=%b, want an=01000 err=1", bus.an, bus.err);
        end
        rst = 1'b1;
        drive(16'h3339, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.seg !== 7'h00 || bus.an !== 5'b00000 || bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got seg=%h an=%b err=%b fd=%b, want all zero",
                     bus.seg, bus.an, bus.err, bus.frame_done);
        end
        @(negedge clk);
        check_release();
    endtask

    initial begin
        rst = 1'b1;
        drive(16'h3333, 1'b0, 1'b0);
        test_reset();
        test_digits();
        test_blanking();
        test_mid_frame();
        test_invalid();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e3_display_scan.md
# e3_display_scan

Time-multiplexed 7-segment display driver. It sits directly downstream of the two's-complement-to-E3 converter and consumes its 16-bit four-digit excess-3 word plus sign flag. It latches a consistent snapshot once per refresh frame. It scans five display positions: four digits plus a sign position. Segment data are registered, with optional leading-zero blanking and invalid-code flagging.

## Interface
- DIV, 50000: clock cycles each position stays lit; legal range DIV ≥ 1.
- E3_CODED, 1: 1 means input nibbles are excess-3 (value+3); 0 means raw BCD.
- ACTIVE_LOW, 1: 1 inverts `seg` and `an` at the outputs.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- E3_in  in  16  digit word; [3:0] units … [15:12] thousands.
- Sign_in  in  1  1 means the value is negative.
- blank_lz  in  1  1 enables leading-zero blanking.
- seg  out  7  segments; bit0=a … bit6=g.
- an  out  5  one-hot position enable; bit0 units … bit3 thousands, bit4 sign.
- err  out  1  latched snapshot contains an invalid nibble.
- frame_done  out  1  one-cycle pulse when a new snapshot is captured.

## Operation
- Prescaler `cnt`, width $clog2(DIV) (min 1), counts 0..DIV-1 and wraps. `tick` = (cnt == DIV-1).
- Position index `idx` (3 bits) advances on `tick`: 0→1→2→3→4→0. Values 5–7 are unreachable; if ever present, the next tick forces 0.
- Snapshot: on `tick` with idx==4, load `E3_in` and `Sign_in` into shadow registers. Assert `frame_done` for that same cycle. Inputs are ignored at all other times.
- Digit decode per nibble n:
  - E3_CODED=1: valid iff 3 ≤ n ≤ 12; d = n−3 (4-bit).
  - E3_CODED=0: valid iff n ≤ 9; d = n.
- Patterns, active-high form:
  - Digits: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Minus = 0x40; E = 0x79; blank = 0x00.
- Invalid nibble displays E, regardless of blanking.
- Leading-zero blanking, when blank_lz=1, evaluated on the shadow word:
  - Thousands is blanked if valid and d==0.
  - Hundreds is blanked if thousands is blanked and hundreds is valid zero.
  - Tens follows the same rule against hundreds.
  - Units is never blanked.
  - An invalid nibble breaks the chain.
- Sign position shows minus if shadow sign is 1, otherwise blank. The minus does not move next to the leading digit.
- `err` is the OR of invalid flags over the four shadow nibbles. It is registered and updates with the snapshot.
- ACTIVE_LOW inversion is applied after registering. Reset values below are given before inversion.

## Timing
- Reset, while rst=1 and the cycle after:
  - cnt=0, idx=0.
  - Shadow word = 16'h3333 if E3_CODED, else 16'h0000; shadow sign = 0.
  - seg=0, an=0, err=0, frame_done=0 (pre-inversion).
- `seg` and `an` are registered from `idx` and the shadow registers, so they lag `idx` by one cycle.
- First clock edge after reset release: an=00001, seg shows the units digit of the reset snapshot.
- Each position is lit for exactly DIV cycles. Frame period is 5·DIV cycles. `frame_done` repeats every 5·DIV cycles; the first pulse is DIV·5 cycles after reset release.
- A new snapshot is first shown at the units position, one cycle after `frame_done`.
- DIV=1: idx advances every cycle and every fifth cycle captures a snapshot.
- Input changes mid-frame have no effect until the next capture.
- rst asserted at any point overrides all other activity on that edge.

## Test plan
Bench parameters: DIV=4, E3_CODED=1, ACTIVE_LOW=0.

- Reset release: one cycle later an=00001, seg=0x3F, err=0. Positions then rotate every 4 cycles; frame_done first pulses at cycle 20.
- E3_in=16'h4B63, Sign_in=1, blank_lz=0; after capture the frame shows:
  - units 0x3F, tens 0x4F, hundreds 0x7F, thousands 0x06, sign 0x40.
- Blanking: E3_in=16'h3338, Sign_in=0.
  - blank_lz=1 → thousands, hundreds and tens 0x00, units 0x6D, sign 0x00.
  - blank_lz=0 → thousands, hundreds and tens 0x3F.
- Invalid code: E3_in=16'h3033, blank_lz=1 → hundreds shows 0x79, tens 0x3F (chain broken), thousands 0x00, err=1 from the capture cycle +1.
- Mid-frame change while idx=2: the display keeps the old snapshot until the next frame_done; frame_done spacing is exactly 20 cycles.
- Reset asserted while idx=3 → next edge seg=0, an=0, err=0; after release the display shows 0 (0x3F at units) and the frame timing restarts.
